// File: rtl/clkgen_pkg.sv
// Shared types for the programmable clock/pulse scheduler.
// Holds the FSM state encoding, the config record and its legality rule.
package clkgen_pkg;

  localparam int CLKGEN_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PHASE = 2'd1,
    RUN   = 2'd2
  } clkgen_state_e;

  typedef struct packed {
    logic [CLKGEN_W-1:0] period;
    logic [CLKGEN_W-1:0] high;
    logic [CLKGEN_W-1:0] phase;
  } clkgen_cfg_t;

  function automatic logic cfg_legal(clkgen_cfg_t c);
    return (c.period != '0) && (c.high <= c.period);
  endfunction

endpackage

// File: rtl/clkgen_cfg_shadow.sv
// Config intake: valid/ready handshake, legality check, one-deep shadow, active config.
// Accept/err register one cycle after the offer; ready stays low while the shadow waits to commit.
module clkgen_cfg_shadow
  import clkgen_pkg::*;
#(
  parameter int DEF_PERIOD = 10,
  parameter int DEF_HIGH   = 1,
  parameter int DEF_PHASE  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_cfg_vld,
  output logic                o_cfg_rdy,
  input  logic [CLKGEN_W-1:0] i_cfg_period,
  input  logic [CLKGEN_W-1:0] i_cfg_high,
  input  logic [CLKGEN_W-1:0] i_cfg_phase,
  output logic                o_cfg_err,
  input  logic                i_commit_ok,
  output logic [CLKGEN_W-1:0] o_act_period,
  output logic [CLKGEN_W-1:0] o_act_high,
  output logic [CLKGEN_W-1:0] o_nxt_period,
  output logic [CLKGEN_W-1:0] o_nxt_high,
  output logic [CLKGEN_W-1:0] o_nxt_phase
);

  clkgen_cfg_t w_in;
  clkgen_cfg_t w_next;
  clkgen_cfg_t r_active;
  clkgen_cfg_t r_shadow;
  logic        r_full;
  logic        r_err;
  logic        w_accept;
  logic        w_legal;
  logic        w_commit;

  assign w_in     = '{period: i_cfg_period, high: i_cfg_high, phase: i_cfg_phase};
  assign w_legal  = cfg_legal(w_in);
  assign w_accept = i_cfg_vld && !r_full;
  assign w_commit = i_commit_ok && r_full;
  // The FSM loads its next period from here, so a commit edge already sees the new values.
  assign w_next   = w_commit ? r_shadow : r_active;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_active <= '{period: CLKGEN_W'(DEF_PERIOD),
                    high:   CLKGEN_W'(DEF_HIGH),
                    phase:  CLKGEN_W'(DEF_PHASE)};
      r_shadow <= '0;
      r_full   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_accept && !w_legal;
      if (w_commit) begin
        r_active <= r_shadow;
        r_full   <= 1'b0;
      end else if (w_accept && w_legal) begin
        r_shadow <= w_in;
        r_full   <= 1'b1;
      end
    end
  end

  assign o_cfg_rdy    = !r_full;
  assign o_cfg_err    = r_err;
  assign o_act_period = r_active.period;
  assign o_act_high   = r_active.high;
  assign o_nxt_period = w_next.period;
  assign o_nxt_high   = w_next.high;
  assign o_nxt_phase  = w_next.phase;

endmodule

// File: rtl/clkgen_sched.sv
// Programmable clock/pulse generator: phase delay, then periods of high/low time from clk.
// First period starts phase cycles after en is sampled; config commits only at period boundaries or in IDLE.
module clkgen_sched
  import clkgen_pkg::*;
#(
  parameter int W          = CLKGEN_W,
  parameter int DEF_PERIOD = 10,
  parameter int DEF_HIGH   = 1,
  parameter int DEF_PHASE  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_period,
  input  logic [W-1:0] cfg_high,
  input  logic [W-1:0] cfg_phase,
  output logic         cfg_err,
  output logic         clk_out,
  output logic         period_start,
  output logic         busy
);

  clkgen_state_e       r_state;
  logic [CLKGEN_W-1:0] r_cnt;
  logic                r_clk_out;
  logic                r_period_start;
  logic [CLKGEN_W-1:0] w_cnt_dec;
  logic [CLKGEN_W-1:0] w_low_from;
  logic [CLKGEN_W-1:0] w_act_period;
  logic [CLKGEN_W-1:0] w_act_high;
  logic [CLKGEN_W-1:0] w_nxt_period;
  logic [CLKGEN_W-1:0] w_nxt_high;
  logic [CLKGEN_W-1:0] w_nxt_phase;
  logic                w_last;
  logic                w_start;

  clkgen_cfg_shadow #(
    .DEF_PERIOD (DEF_PERIOD),
    .DEF_HIGH   (DEF_HIGH),
    .DEF_PHASE  (DEF_PHASE)
  ) u_shadow (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cfg_vld    (cfg_valid),
    .o_cfg_rdy    (cfg_ready),
    .i_cfg_period (cfg_period),
    .i_cfg_high   (cfg_high),
    .i_cfg_phase  (cfg_phase),
    .o_cfg_err    (cfg_err),
    .i_commit_ok  ((r_state == IDLE) || w_last),
    .o_act_period (w_act_period),
    .o_act_high   (w_act_high),
    .o_nxt_period (w_nxt_period),
    .o_nxt_high   (w_nxt_high),
    .o_nxt_phase  (w_nxt_phase)
  );

  // cnt counts down to 0 across a period; 0 marks the last cycle.
  assign w_last     = (r_state == RUN) && (r_cnt == '0);
  assign w_start    = en && (((r_state == IDLE) && (w_nxt_phase == '0)) ||
                             ((r_state == PHASE) && (r_cnt == CLKGEN_W'(1))) ||
                             w_last);
  assign w_cnt_dec  = r_cnt - CLKGEN_W'(1);
  // Position < high is equivalent to remaining count >= period - high.
  assign w_low_from = w_act_period - w_act_high;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_clk_out      <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_period_start <= 1'b0;
      r_clk_out      <= 1'b0;
      if (w_start) begin
        r_state        <= RUN;
        r_cnt          <= w_nxt_period - CLKGEN_W'(1);
        r_period_start <= 1'b1;
        r_clk_out      <= (w_nxt_high != '0);
      end else begin
        case (r_state)
          IDLE: begin
            if (en) begin
              r_state <= PHASE;
              r_cnt   <= w_nxt_phase;
            end
          end
          PHASE: begin
            if (!en) r_state <= IDLE;
            else     r_cnt   <= w_cnt_dec;
          end
          RUN: begin
            if (w_last) begin
              r_state <= IDLE;
            end else begin
              r_cnt     <= w_cnt_dec;
              r_clk_out <= (w_cnt_dec >= w_low_from);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign clk_out      = r_clk_out;
  assign period_start = r_period_start;
  assign busy         = (r_state != IDLE);

endmodule
